// File: rtl/core_wb_pkg.sv
// core_wb_pkg: shared types and helpers for the write-back stage.
// Optional feature macro used by the stage: CORE_WB_FWD_EN.
package core_wb_pkg;

   typedef enum logic [2:0] {
      SRC_ALU  = 3'b000,
      SRC_DMEM = 3'b001,
      SRC_PC4  = 3'b010,
      SRC_IMM  = 3'b011,
      SRC_CSR  = 3'b100
   } wb_src_e;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } mem_size_e;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } wb_state_e;

   // A double on a 32-bit datapath behaves as a word.
   function automatic logic is_misaligned(
      mem_size_e   size,
      logic [2:0]  offset,
      int unsigned nbytes
   );
      int unsigned span;
      span = (size == SZ_D && nbytes >= 8) ? 8 : 4;
      unique case (size)
         SZ_H:       return offset[0];
         SZ_W, SZ_D: return (32'(offset) + span) > nbytes;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/core_wb_if.sv
// core_wb_if: MEM -> WB bundle with valid/ready handshake.
// Master is the MEM stage, slave is the write-back stage.
interface core_wb_if #(
   parameter int XLEN = 32
);
   localparam int OFFW = $clog2(XLEN/8);

   logic            i_valid;
   logic            o_ready;
   logic [2:0]      i_mem_to_reg;
   logic            i_rd_we;
   logic [4:0]      i_rd_addr;
   logic [1:0]      i_d_size;
   logic            i_d_unsigned;
   logic [OFFW-1:0] i_d_offset;
   logic [XLEN-1:0] i_alu_result;
   logic [XLEN-1:0] i_imm;
   logic [XLEN-1:0] i_pc_plus_4;
   logic [XLEN-1:0] i_csr_rdata;

   modport master (
      output i_valid, i_mem_to_reg, i_rd_we, i_rd_addr,
      output i_d_size, i_d_unsigned, i_d_offset,
      output i_alu_result, i_imm, i_pc_plus_4, i_csr_rdata,
      input  o_ready
   );

   modport slave (
      input  i_valid, i_mem_to_reg, i_rd_we, i_rd_addr,
      input  i_d_size, i_d_unsigned, i_d_offset,
      input  i_alu_result, i_imm, i_pc_plus_4, i_csr_rdata,
      output o_ready
   );

endinterface

// File: rtl/core_wb_unit_load_align.sv
// core_load_align: shifts a raw load word down by its byte offset,
// then zero- or sign-extends the selected size to XLEN.
module core_load_align
   import core_wb_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int OFFW = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0] i_rdata,
   input  logic [OFFW-1:0] i_offset,
   input  mem_size_e       i_size,
   input  logic            i_unsigned,
   output logic [XLEN-1:0] o_data
);

   localparam logic [XLEN-1:0] M_B = XLEN'(8'hFF);
   localparam logic [XLEN-1:0] M_H = XLEN'(16'hFFFF);
   localparam logic [XLEN-1:0] M_W = XLEN'(32'hFFFF_FFFF);

   logic [XLEN-1:0] sh;
   logic [XLEN-1:0] mask;
   logic            sgn;

   assign sh = i_rdata >> {i_offset, 3'b000};

   always_comb begin
      mask = {XLEN{1'b1}};
      sgn  = 1'b0;
      unique case (i_size)
         SZ_B: begin mask = M_B; sgn = sh[7];  end
         SZ_H: begin mask = M_H; sgn = sh[15]; end
         SZ_W: begin mask = M_W; sgn = sh[31]; end
         SZ_D: begin mask = (XLEN > 32) ? {XLEN{1'b1}} : M_W; sgn = 1'b0; end
      endcase
   end

   assign o_data = (sh & mask)
                 | ({XLEN{sgn & ~i_unsigned}} & ~mask);

endmodule

// File: rtl/core_wb_unit.sv
// core_wb_unit: registered write-back stage with decoupled load wait.
// Define CORE_WB_FWD_EN to drive the early-forward port.
module core_wb_unit
   import core_wb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            i_clk,
   input  logic            i_rst,
   core_wb_if.slave        mem_if,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_rd_we,
   output logic [4:0]      o_rd_addr,
   output logic [XLEN-1:0] o_rd_din,
   output logic            o_stall,
   output logic            o_misaligned,
   output logic            o_timeout,
   output logic            o_resp_err,
   output logic            o_fwd_valid,
   output logic [4:0]      o_fwd_rd,
   output logic [XLEN-1:0] o_fwd_data
);

   localparam int OFFW = $clog2(XLEN/8);
   localparam int CW   = $clog2(TIMEOUT+1);

   wb_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      ld_rd_q, ld_rd_d;
   logic            ld_we_q, ld_we_d;
   mem_size_e       ld_sz_q, ld_sz_d;
   logic            ld_un_q, ld_un_d;
   logic [OFFW-1:0] ld_off_q, ld_off_d;
   logic            we_q, we_d;
   logic [4:0]      addr_q, addr_d;
   logic [XLEN-1:0] din_q, din_d;
   logic            mis_q, mis_d;
   logic            tmo_q, tmo_d;
   logic            err_q, err_d;

   logic            accept;
   logic [XLEN-1:0] src_val;
   logic [XLEN-1:0] ld_data;

   assign mem_if.o_ready = (state_q == S_IDLE);
   assign accept = mem_if.i_valid & (state_q == S_IDLE);

   always_comb begin
      case (mem_if.i_mem_to_reg)
         SRC_PC4: src_val = mem_if.i_pc_plus_4;
         SRC_IMM: src_val = mem_if.i_imm;
         SRC_CSR: src_val = mem_if.i_csr_rdata;
         default: src_val = mem_if.i_alu_result;
      endcase
   end

   core_load_align #(.XLEN(XLEN)) u_align (
      .i_rdata    (i_dmem_rdata),
      .i_offset   (ld_off_q),
      .i_size     (ld_sz_q),
      .i_unsigned (ld_un_q),
      .o_data     (ld_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ld_rd_d  = ld_rd_q;
      ld_we_d  = ld_we_q;
      ld_sz_d  = ld_sz_q;
      ld_un_d  = ld_un_q;
      ld_off_d = ld_off_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      mis_d    = 1'b0;
      tmo_d    = 1'b0;
      // A response arriving while idle has no owner.
      err_d    = i_dmem_rvalid & (state_q == S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (accept && mem_if.i_mem_to_reg == SRC_DMEM) begin
               state_d  = S_WAIT;
               cnt_d    = '0;
               ld_rd_d  = mem_if.i_rd_addr;
               ld_we_d  = mem_if.i_rd_we;
               ld_sz_d  = mem_size_e'(mem_if.i_d_size);
               ld_un_d  = mem_if.i_d_unsigned;
               ld_off_d = mem_if.i_d_offset;
            end else if (accept) begin
               we_d   = mem_if.i_rd_we & (|mem_if.i_rd_addr);
               addr_d = mem_if.i_rd_addr;
               din_d  = src_val;
            end
         end
         S_WAIT: begin
            if (i_dmem_rvalid) begin
               state_d = S_IDLE;
               we_d    = ld_we_q & (|ld_rd_q);
               addr_d  = ld_rd_q;
               din_d   = ld_data;
               mis_d   = is_misaligned(ld_sz_q, 3'(ld_off_q), XLEN/8);
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               state_d = S_IDLE;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ld_rd_q  <= '0;
         ld_we_q  <= 1'b0;
         ld_sz_q  <= SZ_B;
         ld_un_q  <= 1'b0;
         ld_off_q <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         mis_q    <= 1'b0;
         tmo_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ld_rd_q  <= ld_rd_d;
         ld_we_q  <= ld_we_d;
         ld_sz_q  <= ld_sz_d;
         ld_un_q  <= ld_un_d;
         ld_off_q <= ld_off_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         mis_q    <= mis_d;
         tmo_q    <= tmo_d;
         err_q    <= err_d;
      end
   end

   assign o_rd_we      = we_q;
   assign o_rd_addr    = addr_q;
   assign o_rd_din     = din_q;
   assign o_stall      = (state_q == S_WAIT);
   assign o_misaligned = mis_q;
   assign o_timeout    = tmo_q;
   assign o_resp_err   = err_q;

`ifdef CORE_WB_FWD_EN
   assign o_fwd_valid = we_d & ~i_rst;
   assign o_fwd_rd    = addr_d;
   assign o_fwd_data  = din_d;
`else
   assign o_fwd_valid = 1'b0;
   assign o_fwd_rd    = '0;
   assign o_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_core_wb_unit.sv
// tb_core_wb_unit: vectors and hand sequences for core_wb_unit,
// a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_core_wb_unit;
   import core_wb_pkg::*;

`ifdef CORE_WB_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   core_wb_if #(.XLEN(32)) if32 ();
   core_wb_if #(.XLEN(64)) if64 ();

   logic        rv32;
   logic [31:0] rdat32;
   logic        we32, stall32, mis32, tmo32, err32, fv32;
   logic [4:0]  addr32, frd32;
   logic [31:0] din32, fd32;

   logic        rv64;
   logic [63:0] rdat64;
   logic        we64, stall64, mis64, tmo64, err64, fv64;
   logic [4:0]  addr64, frd64;
   logic [63:0] din64, fd64;

   core_wb_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
      .i_clk(clk), .i_rst(rst), .mem_if(if32.slave),
      .i_dmem_rvalid(rv32), .i_dmem_rdata(rdat32),
      .o_rd_we(we32), .o_rd_addr(addr32), .o_rd_din(din32),
      .o_stall(stall32), .o_misaligned(mis32),
      .o_timeout(tmo32), .o_resp_err(err32),
      .o_fwd_valid(fv32), .o_fwd_rd(frd32), .o_fwd_data(fd32)
   );

   core_wb_unit #(.XLEN(64), .TIMEOUT(255)) u64 (
      .i_clk(clk), .i_rst(rst), .mem_if(if64.slave),
      .i_dmem_rvalid(rv64), .i_dmem_rdata(rdat64),
      .o_rd_we(we64), .o_rd_addr(addr64), .o_rd_din(din64),
      .o_stall(stall64), .o_misaligned(mis64),
      .o_timeout(tmo64), .o_resp_err(err64),
      .o_fwd_valid(fv64), .o_fwd_rd(frd64), .o_fwd_data(fd64)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] din;
   } sb_t;
   sb_t sb[$];
   sb_t e;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && we32) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_extra: write x%0d=%0h, expected none",
                     addr32, din32);
         end else begin
            e = sb.pop_front();
            chk("sb_addr", 64'(addr32), 64'(e.rd));
            chk("sb_din", 64'(din32), 64'(e.din));
         end
      end
   end

   typedef struct {
      logic [2:0]  src;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] alu, imm, pc4, csr;
      logic        exp_we;
      logic [31:0] exp_din;
   } nl_t;

   typedef struct {
      logic [1:0]  sz;
      logic        un;
      logic [2:0]  off;
      logic [63:0] rdata;
      int          dly;
      logic [63:0] exp_din;
      logic        exp_mis;
   } ld_t;

   nl_t nl[7];
   ld_t l32[7];
   ld_t l64[6];

   task automatic idle32();
      if32.i_valid = 0; if32.i_mem_to_reg = 0; if32.i_rd_we = 0;
      if32.i_rd_addr = 0; if32.i_d_size = 0; if32.i_d_unsigned = 0;
      if32.i_d_offset = 0; if32.i_alu_result = 0; if32.i_imm = 0;
      if32.i_pc_plus_4 = 0; if32.i_csr_rdata = 0;
      rv32 = 0; rdat32 = 0;
   endtask

   task automatic idle64();
      if64.i_valid = 0; if64.i_mem_to_reg = 0; if64.i_rd_we = 0;
      if64.i_rd_addr = 0; if64.i_d_size = 0; if64.i_d_unsigned = 0;
      if64.i_d_offset = 0; if64.i_alu_result = 0; if64.i_imm = 0;
      if64.i_pc_plus_4 = 0; if64.i_csr_rdata = 0;
      rv64 = 0; rdat64 = 0;
   endtask

   task automatic ld32(logic [1:0] sz, logic un, logic [1:0] off,
                       logic [4:0] rd);
      if32.i_valid = 1; if32.i_mem_to_reg = 3'b001; if32.i_rd_we = 1;
      if32.i_rd_addr = rd; if32.i_d_size = sz;
      if32.i_d_unsigned = un; if32.i_d_offset = off;
   endtask

   initial begin
      nl[0] = '{3'b000, 1, 5'd5, 32'h1234_5678, 32'h0, 32'h0, 32'h0,
                1, 32'h1234_5678};
      nl[1] = '{3'b010, 1, 5'd6, 32'h1, 32'h2, 32'h0000_1004, 32'h3,
                1, 32'h0000_1004};
      nl[2] = '{3'b011, 1, 5'd7, 32'h1, 32'hFFFF_F800, 32'h2, 32'h3,
                1, 32'hFFFF_F800};
      nl[3] = '{3'b100, 1, 5'd31, 32'h1, 32'h2, 32'h3, 32'hC5C5_0001,
                1, 32'hC5C5_0001};
      nl[4] = '{3'b110, 1, 5'd1, 32'hDEAD_BEEF, 32'h2, 32'h3, 32'h4,
                1, 32'hDEAD_BEEF};
      nl[5] = '{3'b000, 1, 5'd0, 32'h0BAD_0BAD, 32'h0, 32'h0, 32'h0,
                0, 32'h0BAD_0BAD};
      nl[6] = '{3'b010, 0, 5'd9, 32'h0, 32'h0, 32'h0000_2000, 32'h0,
                0, 32'h0000_2000};

      l32[0] = '{2'b00, 0, 3'd2, 64'hAA80_1122, 3, 64'hFFFF_FF80, 0};
      l32[1] = '{2'b01, 1, 3'd1, 64'h1234_5678, 1, 64'h0000_3456, 1};
      l32[2] = '{2'b01, 0, 3'd2, 64'h8001_0000, 2, 64'hFFFF_8001, 0};
      l32[3] = '{2'b10, 0, 3'd0, 64'h8000_0001, 1, 64'h8000_0001, 0};
      l32[4] = '{2'b10, 0, 3'd1, 64'hDDCC_BBAA, 1, 64'h00DD_CCBB, 1};
      l32[5] = '{2'b11, 0, 3'd0, 64'h1111_2222, 4, 64'h1111_2222, 0};
      l32[6] = '{2'b00, 1, 3'd3, 64'hF000_0000, 1, 64'h0000_00F0, 0};

      l64[0] = '{2'b10, 1, 3'd4, 64'h8765_4321_0000_0000, 1,
                 64'h0000_0000_8765_4321, 0};
      l64[1] = '{2'b10, 0, 3'd4, 64'h8765_4321_0000_0000, 1,
                 64'hFFFF_FFFF_8765_4321, 0};
      l64[2] = '{2'b11, 0, 3'd0, 64'h0123_4567_89AB_CDEF, 2,
                 64'h0123_4567_89AB_CDEF, 0};
      l64[3] = '{2'b11, 0, 3'd4, 64'h8765_4321_0000_0000, 1,
                 64'h0000_0000_8765_4321, 1};
      l64[4] = '{2'b00, 0, 3'd7, 64'h8000_0000_0000_0000, 1,
                 64'hFFFF_FFFF_FFFF_FF80, 0};
      l64[5] = '{2'b01, 0, 3'd6, 64'hFFEE_0000_0000_0000, 1,
                 64'hFFFF_FFFF_FFFF_FFEE, 0};

      idle32();
      idle64();
      rst = 1;
      step();
      step();
      chk("rst_ready", 64'(if32.o_ready), 1);
      chk("rst_stall", 64'(stall32), 0);
      chk("rst_we", 64'(we32), 0);
      chk("rst_addr", 64'(addr32), 0);
      chk("rst_din", 64'(din32), 0);
      chk("rst_flags", 64'({mis32, tmo32, err32}), 0);
      chk("rst_ready64", 64'(if64.o_ready), 1);
      rst = 0;
      step();

      foreach (nl[i]) begin
         if32.i_valid = 1;
         if32.i_mem_to_reg = nl[i].src;
         if32.i_rd_we = nl[i].we;
         if32.i_rd_addr = nl[i].rd;
         if32.i_alu_result = nl[i].alu;
         if32.i_imm = nl[i].imm;
         if32.i_pc_plus_4 = nl[i].pc4;
         if32.i_csr_rdata = nl[i].csr;
         if (nl[i].exp_we) sb.push_back('{nl[i].rd, nl[i].exp_din});
         #1;
         chk("nl_fwd", 64'(fv32), 64'(FWD & nl[i].exp_we));
         step();
         if32.i_valid = 0;
         chk("nl_we", 64'(we32), 64'(nl[i].exp_we));
         chk("nl_addr", 64'(addr32), 64'(nl[i].rd));
         chk("nl_din", 64'(din32), 64'(nl[i].exp_din));
         chk("nl_ready", 64'(if32.o_ready), 1);
      end

      foreach (l32[i]) begin
         ld32(l32[i].sz, l32[i].un, l32[i].off[1:0], 5'(8 + i));
         step();
         if32.i_valid = 0;
         chk("ld_stall", 64'(stall32), 1);
         chk("ld_nready", 64'(if32.o_ready), 0);
         repeat (l32[i].dly - 1) step();
         rv32 = 1;
         rdat32 = l32[i].rdata[31:0];
         sb.push_back('{5'(8 + i), l32[i].exp_din[31:0]});
         #1;
         chk("ld_fwd", 64'(fv32), 64'(FWD));
         step();
         rv32 = 0;
         chk("ld_we", 64'(we32), 1);
         chk("ld_din", 64'(din32), l32[i].exp_din);
         chk("ld_mis", 64'(mis32), 64'(l32[i].exp_mis));
         chk("ld_tmo", 64'(tmo32), 0);
         chk("ld_ready", 64'(if32.o_ready), 1);
      end

      ld32(2'b10, 0, 2'd0, 5'd4);
      step();
      if32.i_valid = 0;
      for (int c = 0; c < 4; c++) begin
         chk("to_stall", 64'(stall32), 1);
         chk("to_early", 64'(tmo32), 0);
         step();
      end
      chk("to_pulse", 64'(tmo32), 1);
      chk("to_nowe", 64'(we32), 0);
      chk("to_ready", 64'(if32.o_ready), 1);
      chk("to_unstall", 64'(stall32), 0);
      step();
      chk("to_end", 64'(tmo32), 0);

      rv32 = 1;
      step();
      rv32 = 0;
      chk("err_idle", 64'(err32), 1);
      chk("err_nowe", 64'(we32), 0);
      step();
      chk("err_pulse", 64'(err32), 0);

      ld32(2'b10, 0, 2'd0, 5'd11);
      rv32 = 1;
      rdat32 = 32'h5555_AAAA;
      step();
      if32.i_valid = 0;
      rv32 = 0;
      chk("acc_err", 64'(err32), 1);
      chk("acc_stall", 64'(stall32), 1);
      chk("acc_nowe", 64'(we32), 0);
      rv32 = 1;
      rdat32 = 32'h0F0F_1234;
      sb.push_back('{5'd11, 32'h0F0F_1234});
      step();
      rv32 = 0;
      chk("acc_din", 64'(din32), 64'h0F0F_1234);
      chk("acc_noerr", 64'(err32), 0);

      ld32(2'b10, 0, 2'd0, 5'd12);
      step();
      if32.i_valid = 0;
      step();
      rst = 1;
      step();
      rst = 0;
      chk("mr_ready", 64'(if32.o_ready), 1);
      chk("mr_stall", 64'(stall32), 0);
      rv32 = 1;
      rdat32 = 32'h7777_7777;
      #1;
      chk("mr_fwd", 64'(fv32), 0);
      step();
      rv32 = 0;
      chk("mr_err", 64'(err32), 1);
      chk("mr_nowe", 64'(we32), 0);
      chk("mr_fwd2", 64'(fv32), 0);

      if64.i_valid = 1;
      if64.i_rd_we = 1;
      if64.i_rd_addr = 5'd3;
      if64.i_alu_result = 64'hFEDC_BA98_7654_3210;
      step();
      if64.i_valid = 0;
      chk("x64_we", 64'(we64), 1);
      chk("x64_din", din64, 64'hFEDC_BA98_7654_3210);

      foreach (l64[i]) begin
         if64.i_valid = 1;
         if64.i_mem_to_reg = 3'b001;
         if64.i_rd_we = 1;
         if64.i_rd_addr = 5'd20;
         if64.i_d_size = l64[i].sz;
         if64.i_d_unsigned = l64[i].un;
         if64.i_d_offset = l64[i].off;
         step();
         if64.i_valid = 0;
         chk("x64_stall", 64'(stall64), 1);
         repeat (l64[i].dly - 1) step();
         rv64 = 1;
         rdat64 = l64[i].rdata;
         step();
         rv64 = 0;
         chk("x64_ldwe", 64'(we64), 1);
         chk("x64_lddin", din64, l64[i].exp_din);
         chk("x64_mis", 64'(mis64), 64'(l64[i].exp_mis));
      end

      step();
      chk("sb_empty", 64'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
